// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: opcodes, ALU/branch/cmd/sx/byte-enable
// codes, FSM state type, the decoded-field bundle and the per-class mux_sel table.
package ctrl_pkg;

    // Opcode classes
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_RI    = 7'b0010011;
    localparam logic [6:0] OP_JL    = 7'b1100111;  // JALR and loads share this opcode
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_SB    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_UJ    = 7'b1101111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLT  = 4'd1;
    localparam logic [3:0] ALU_SLTU = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SUB  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_AM   = 4'd10;

    // Branch type: MSB marks a branch, low bits select the compare
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQ   = 3'b100;
    localparam logic [2:0] BR_NE   = 3'b101;
    localparam logic [2:0] BR_LT   = 3'b110;
    localparam logic [2:0] BR_GE   = 3'b111;

    // Memory / control-flow command
    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_JMP  = 2'b01;
    localparam logic [1:0] CMD_ST   = 2'b10;
    localparam logic [1:0] CMD_LW   = 2'b11;

    // Load extension: [2]=full word, [1]=halfword, [0]=zero-extend
    localparam logic [2:0] SX_B  = 3'b000;
    localparam logic [2:0] SX_BU = 3'b001;
    localparam logic [2:0] SX_H  = 3'b010;
    localparam logic [2:0] SX_HU = 3'b011;
    localparam logic [2:0] SX_W  = 3'b100;

    // Memory access width
    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_B    = 2'b01;
    localparam logic [1:0] BE_H    = 2'b10;
    localparam logic [1:0] BE_W    = 2'b11;

    // Datapath mux-select per instruction class (native width 11, resized to MUX_N)
    localparam int MUX_BASE_W = 11;
    localparam logic [MUX_BASE_W-1:0] MUX_NONE  = 11'h000;
    localparam logic [MUX_BASE_W-1:0] MUX_R     = 11'h001;
    localparam logic [MUX_BASE_W-1:0] MUX_I     = 11'h006;
    localparam logic [MUX_BASE_W-1:0] MUX_JALR  = 11'h04A;
    localparam logic [MUX_BASE_W-1:0] MUX_LOAD  = 11'h01A;
    localparam logic [MUX_BASE_W-1:0] MUX_STORE = 11'h022;
    localparam logic [MUX_BASE_W-1:0] MUX_BR    = 11'h101;
    localparam logic [MUX_BASE_W-1:0] MUX_LUI   = 11'h208;
    localparam logic [MUX_BASE_W-1:0] MUX_AUIPC = 11'h20C;
    localparam logic [MUX_BASE_W-1:0] MUX_UJ    = 11'h44C;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_TRAP     = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_s_u;
        logic [2:0] brn_type;
        logic [2:0] sx_cntl;
        logic [1:0] be_mem;
        logic       we_mem;
        logic       we_reg;
        logic [1:0] cmd;
    } ctrl_fields_t;

    // Neutral field values: used at reset and for anything that decodes as illegal
    localparam ctrl_fields_t CTRL_DEFAULT = '{
        alu_op:   ALU_ADD,
        alu_s_u:  1'b0,
        brn_type: BR_NONE,
        sx_cntl:  SX_W,
        be_mem:   BE_NONE,
        we_mem:   1'b0,
        we_reg:   1'b0,
        cmd:      CMD_NONE
    };

    // ALU op for the plain (fnct7=00) register/immediate forms
    function automatic logic [3:0] base_alu(input logic [2:0] fnct);
        case (fnct)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decode: instr -> control fields, mux_sel, illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int MUX_N = 11,
    parameter int EN_AM = 1
) (
    input  logic [31:0]      instr,
    output ctrl_fields_t     fields,
    output logic [MUX_N-1:0] mux_sel,
    output logic             illegal
);

    logic [6:0]            opcode;
    logic [2:0]            fnct;
    logic [1:0]            fnct7;
    logic [MUX_BASE_W-1:0] mux_raw;
    logic                  bad;
    logic                  unused_bits;

    assign opcode = instr[6:0];
    assign fnct   = instr[14:12];
    assign fnct7  = {instr[30], instr[25]};
    // Register and immediate fields are consumed by the datapath, not here
    assign unused_bits = ^{instr[31], instr[29:26], instr[24:15], instr[11:7]};

    // Decode every opcode/fnct combination; illegal encodings fall back to neutral fields
    always_comb begin
        fields  = CTRL_DEFAULT;
        mux_raw = MUX_NONE;
        bad     = 1'b0;
        case (opcode)
            OP_R: begin
                mux_raw       = MUX_R;
                fields.we_reg = 1'b1;
                case (fnct7)
                    2'b00: fields.alu_op = base_alu(fnct);
                    2'b10: begin
                        if (fnct == 3'b000)      fields.alu_op = ALU_SUB;
                        else if (fnct == 3'b101) fields.alu_op = ALU_SRA;
                        else                     bad = 1'b1;
                    end
                    2'b01: begin
                        if (fnct == 3'b111 && EN_AM != 0) fields.alu_op = ALU_AM;
                        else                              bad = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_RI: begin
                // fnct7 bits are immediate bits except for the shift forms
                mux_raw       = MUX_I;
                fields.we_reg = 1'b1;
                case (fnct)
                    3'b001: begin
                        if (fnct7 == 2'b00) fields.alu_op = ALU_SLL;
                        else                bad = 1'b1;
                    end
                    3'b101: begin
                        case (fnct7)
                            2'b00:   fields.alu_op = ALU_SRL;
                            2'b10:   fields.alu_op = ALU_SRA;
                            default: bad = 1'b1;
                        endcase
                    end
                    default: fields.alu_op = base_alu(fnct);
                endcase
            end
            OP_JL: begin
                fields.we_reg = 1'b1;
                fields.cmd    = CMD_LW;
                mux_raw       = MUX_LOAD;
                case (fnct)
                    3'b000: begin
                        fields.cmd = CMD_JMP;
                        mux_raw    = MUX_JALR;
                    end
                    3'b001: begin fields.be_mem = BE_W; fields.sx_cntl = SX_W;  end
                    3'b010: begin fields.be_mem = BE_H; fields.sx_cntl = SX_H;  end
                    3'b011: begin fields.be_mem = BE_H; fields.sx_cntl = SX_HU; end
                    3'b100: begin fields.be_mem = BE_B; fields.sx_cntl = SX_B;  end
                    3'b101: begin fields.be_mem = BE_B; fields.sx_cntl = SX_BU; end
                    default: bad = 1'b1;
                endcase
            end
            OP_S: begin
                fields.cmd    = CMD_ST;
                fields.we_mem = 1'b1;
                mux_raw       = MUX_STORE;
                case (fnct)
                    3'b001:  fields.be_mem = BE_W;
                    3'b010:  fields.be_mem = BE_H;
                    3'b011:  fields.be_mem = BE_B;
                    default: bad = 1'b1;
                endcase
            end
            OP_SB: begin
                fields.alu_op  = ALU_SUB;
                fields.alu_s_u = ~(fnct[2] & fnct[1]);  // 110/111 compare unsigned
                mux_raw        = MUX_BR;
                case (fnct)
                    3'b000, 3'b001: fields.brn_type = fnct[0] ? BR_NE : BR_EQ;
                    3'b100, 3'b110: fields.brn_type = BR_LT;
                    3'b101, 3'b111: fields.brn_type = BR_GE;
                    default:        bad = 1'b1;
                endcase
            end
            OP_LUI: begin
                fields.we_reg = 1'b1;
                mux_raw       = MUX_LUI;
            end
            OP_AUIPC: begin
                fields.we_reg = 1'b1;
                mux_raw       = MUX_AUIPC;
            end
            OP_UJ: begin
                fields.we_reg = 1'b1;
                fields.cmd    = CMD_JMP;
                mux_raw       = MUX_UJ;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            fields  = CTRL_DEFAULT;
            mux_raw = MUX_NONE;
        end
    end

    assign mux_sel = MUX_N'(mux_raw);
    assign illegal = bad;

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Control sequencer: accepts instructions, holds the registered decode until the
// consumer takes it, waits on memory for loads/stores, and traps on faults.
module cpu_ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int MUX_N  = 11,
    parameter int CNT_W  = 8,
    parameter int MEM_TO = 16,
    parameter int EN_AM  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             flush,
    input  logic             trap_clr,
    input  logic             mem_ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_op,
    output logic             alu_s_u,
    output logic [2:0]       brn_type,
    output logic [2:0]       sx_cntl,
    output logic [1:0]       be_mem,
    output logic             we_mem,
    output logic             we_reg,
    output logic [1:0]       cmd,
    output logic [MUX_N-1:0] mux_sel,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Timer counts completed MEM_WAIT cycles; the last allowed one is MEM_TO-1
    localparam int TMR_W = $clog2(MEM_TO + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TO - 1);

    ctrl_fields_t     dec_fields;
    logic [MUX_N-1:0] dec_mux;
    logic             dec_illegal;

    state_e           state_q, state_d;
    ctrl_fields_t     fields_q, fields_d;
    logic [MUX_N-1:0] mux_q, mux_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             take;

    ctrl_decode #(
        .MUX_N (MUX_N),
        .EN_AM (EN_AM)
    ) u_decode (
        .instr   (instr),
        .fields  (dec_fields),
        .mux_sel (dec_mux),
        .illegal (dec_illegal)
    );

    // Next-state, handshake and status update
    always_comb begin
        state_d       = state_q;
        fields_d      = fields_q;
        mux_d         = mux_q;
        illegal_d     = illegal_q;
        mem_err_d     = mem_err_q;
        illegal_cnt_d = illegal_cnt_q;
        timer_d       = '0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        take          = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                take     = in_valid;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    if (fields_q.cmd == CMD_LW || fields_q.cmd == CMD_ST) begin
                        state_d = S_MEM_WAIT;
                    end else begin
                        // Slot frees this cycle, so a new instruction can slide in
                        state_d  = S_IDLE;
                        in_ready = 1'b1;
                        take     = in_valid;
                    end
                end
            end
            S_MEM_WAIT: begin
                // An ack on the final allowed cycle still completes normally
                if (mem_ack) begin
                    state_d = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    mem_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                if (trap_clr) begin
                    state_d   = S_IDLE;
                    illegal_d = 1'b0;
                    mem_err_d = 1'b0;
                end
            end
        endcase
        if (take) begin
            if (dec_illegal) begin
                illegal_d = 1'b1;
                state_d   = S_TRAP;
                if (illegal_cnt_q != {CNT_W{1'b1}}) begin
                    illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
                end
            end else begin
                fields_d = dec_fields;
                mux_d    = dec_mux;
                state_d  = S_HOLD;
            end
        end
    end

    // State and datapath-control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            fields_q      <= CTRL_DEFAULT;
            mux_q         <= '0;
            illegal_q     <= 1'b0;
            mem_err_q     <= 1'b0;
            illegal_cnt_q <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            fields_q      <= fields_d;
            mux_q         <= mux_d;
            illegal_q     <= illegal_d;
            mem_err_q     <= mem_err_d;
            illegal_cnt_q <= illegal_cnt_d;
            timer_q       <= timer_d;
        end
    end

    assign alu_op      = fields_q.alu_op;
    assign alu_s_u     = fields_q.alu_s_u;
    assign brn_type    = fields_q.brn_type;
    assign sx_cntl     = fields_q.sx_cntl;
    assign be_mem      = fields_q.be_mem;
    assign cmd         = fields_q.cmd;
    assign mux_sel     = mux_q;
    assign we_mem      = fields_q.we_mem & out_valid;
    assign we_reg      = fields_q.we_reg & out_valid;
    assign illegal     = illegal_q;
    assign mem_err     = mem_err_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: main instance with defaults, second with EN_AM=0.
module tb_cpu_ctrl_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, flush, trap_clr, mem_ack, out_ready;
    logic [31:0] instr;
    logic        in_ready, out_valid, alu_s_u, we_mem, we_reg, illegal, mem_err;
    logic [3:0]  alu_op;
    logic [2:0]  brn_type, sx_cntl;
    logic [1:0]  be_mem, cmd;
    logic [10:0] mux_sel;
    logic [7:0]  illegal_cnt;

    logic        in_valid_b;
    logic [31:0] instr_b;
    logic        in_ready_b, out_valid_b, alu_s_u_b, we_mem_b, we_reg_b, illegal_b, mem_err_b;
    logic [3:0]  alu_op_b;
    logic [2:0]  brn_type_b, sx_cntl_b;
    logic [1:0]  be_mem_b, cmd_b;
    logic [10:0] mux_sel_b;
    logic [7:0]  illegal_cnt_b;

    int checks   = 0;
    int failures = 0;
    int ov_seen;

    cpu_ctrl_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .trap_clr(trap_clr), .mem_ack(mem_ack),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .alu_s_u(alu_s_u), .brn_type(brn_type), .sx_cntl(sx_cntl),
        .be_mem(be_mem), .we_mem(we_mem), .we_reg(we_reg), .cmd(cmd), .mux_sel(mux_sel),
        .illegal(illegal), .mem_err(mem_err), .illegal_cnt(illegal_cnt)
    );

    cpu_ctrl_seq #(.EN_AM(0)) dut_noam (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .instr(instr_b),
        .flush(1'b0), .trap_clr(1'b0), .mem_ack(1'b0),
        .out_valid(out_valid_b), .out_ready(1'b1),
        .alu_op(alu_op_b), .alu_s_u(alu_s_u_b), .brn_type(brn_type_b), .sx_cntl(sx_cntl_b),
        .be_mem(be_mem_b), .we_mem(we_mem_b), .we_reg(we_reg_b), .cmd(cmd_b), .mux_sel(mux_sel_b),
        .illegal(illegal_b), .mem_err(mem_err_b), .illegal_cnt(illegal_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one instruction in IDLE; returns with the decode held (out_ready low)
    task automatic accept(input logic [31:0] ins);
        in_valid = 1'b1;
        instr    = ins;
        tick();
        in_valid = 1'b0;
    endtask

    // Hand a load/store to the consumer and ack it on the first wait cycle
    task automatic finish_mem();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        mem_ack   = 1'b1;
        tick();
        mem_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; trap_clr = 1'b0;
        mem_ack = 1'b0; out_ready = 1'b0; in_valid_b = 1'b0; instr_b = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        $display("txn reset");
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_sx_cntl", sx_cntl, 3'b100);
        chk("rst_cmd", cmd, 0);
        chk("rst_be_mem", be_mem, 0);
        chk("rst_mux_sel", mux_sel, 0);
        chk("rst_we_reg", we_reg, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_cnt", illegal_cnt, 0);

        $display("txn r_add instr=00208033");
        accept(32'h00208033);
        chk("add_out_valid", out_valid, 1);
        chk("add_alu_op", alu_op, 0);
        chk("add_we_reg", we_reg, 1);
        chk("add_cmd", cmd, 0);
        chk("add_mux_sel", mux_sel, 11'h001);
        out_ready = 1'b1;
        tick();
        chk("add_done_valid", out_valid, 0);
        chk("add_done_we_reg", we_reg, 0);
        out_ready = 1'b0;

        $display("txn b2b sub=40208033 xor=0020c033");
        accept(32'h40208033);
        chk("sub_alu_op", alu_op, 8);
        in_valid  = 1'b1;
        instr     = 32'h0020C033;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("xor_out_valid", out_valid, 1);
        chk("xor_alu_op", alu_op, 5);
        tick();
        chk("b2b_idle_valid", out_valid, 0);
        out_ready = 1'b0;

        $display("txn flush lw=00001067");
        accept(32'h00001067);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_we_reg", we_reg, 0);
        chk("flush_in_ready", in_ready, 1);

        $display("txn lw 3-cycle ack");
        accept(32'h00001067);
        chk("lw_out_valid", out_valid, 1);
        chk("lw_cmd", cmd, 2'b11);
        chk("lw_sx_cntl", sx_cntl, 3'b100);
        chk("lw_be_mem", be_mem, 2'b11);
        chk("lw_we_reg", we_reg, 1);
        chk("lw_mux_sel", mux_sel, 11'h01A);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("lw_w1_in_ready", in_ready, 0);
        chk("lw_w1_out_valid", out_valid, 0);
        tick();
        chk("lw_w2_in_ready", in_ready, 0);
        tick();
        chk("lw_w3_in_ready", in_ready, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("lw_done_in_ready", in_ready, 1);
        chk("lw_done_mem_err", mem_err, 0);

        $display("txn lh=00002067");
        accept(32'h00002067);
        chk("lh_sx_cntl", sx_cntl, 3'b010);
        chk("lh_be_mem", be_mem, 2'b10);
        finish_mem();
        chk("lh_done_in_ready", in_ready, 1);

        $display("txn sb=00003023");
        accept(32'h00003023);
        chk("sb_we_mem", we_mem, 1);
        chk("sb_we_reg", we_reg, 0);
        chk("sb_cmd", cmd, 2'b10);
        chk("sb_be_mem", be_mem, 2'b01);
        finish_mem();
        chk("sb_done_we_mem", we_mem, 0);

        $display("txn bltu=00006063");
        accept(32'h00006063);
        chk("bltu_brn", brn_type, 3'b110);
        chk("bltu_alu_op", alu_op, 8);
        chk("bltu_s_u", alu_s_u, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("txn beq=00000063");
        accept(32'h00000063);
        chk("beq_brn", brn_type, 3'b100);
        chk("beq_s_u", alu_s_u, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("txn srai=40005013");
        accept(32'h40005013);
        chk("srai_alu_op", alu_op, 9);
        chk("srai_mux_sel", mux_sel, 11'h006);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("txn jal=0000006f");
        accept(32'h0000006F);
        chk("jal_cmd", cmd, 2'b01);
        chk("jal_we_reg", we_reg, 1);
        chk("jal_mux_sel", mux_sel, 11'h44C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("txn am=0200f033 en_am=1");
        accept(32'h0200F033);
        chk("am_out_valid", out_valid, 1);
        chk("am_alu_op", alu_op, 10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("txn am=0200f033 en_am=0");
        in_valid_b = 1'b1;
        instr_b    = 32'h0200F033;
        tick();
        in_valid_b = 1'b0;
        chk("noam_illegal", illegal_b, 1);
        chk("noam_out_valid", out_valid_b, 0);
        chk("noam_cnt", illegal_cnt_b, 1);

        $display("txn lw timeout");
        accept(32'h00001067);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (15) tick();
        chk("to_pre_mem_err", mem_err, 0);
        chk("to_pre_in_ready", in_ready, 0);
        tick();
        chk("to_mem_err", mem_err, 1);
        chk("to_trap_in_ready", in_ready, 0);
        chk("to_trap_out_valid", out_valid, 0);
        trap_clr = 1'b1;
        tick();
        trap_clr = 1'b0;
        chk("to_clr_mem_err", mem_err, 0);
        chk("to_clr_in_ready", in_ready, 1);

        $display("txn lw ack on last wait cycle");
        accept(32'h00001067);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (15) tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("lastack_mem_err", mem_err, 0);
        chk("lastack_in_ready", in_ready, 1);

        $display("txn 300 illegal 0000007f");
        ov_seen = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            instr    = 32'h0000007F;
            tick();
            in_valid = 1'b0;
            if (out_valid) ov_seen++;
            if (i == 0) begin
                chk("ill_flag", illegal, 1);
                chk("ill_cnt1", illegal_cnt, 1);
            end
            trap_clr = 1'b1;
            tick();
            trap_clr = 1'b0;
            if (out_valid) ov_seen++;
            if (i == 0) chk("ill_clr_flag", illegal, 0);
        end
        chk("ill_cnt_sat", illegal_cnt, 255);
        chk("ill_no_out_valid", ov_seen, 0);

        $display("txn reset from trap");
        accept(32'h0000007F);
        chk("sat_hold_cnt", illegal_cnt, 255);
        chk("sat_hold_flag", illegal, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_trap_illegal", illegal, 0);
        chk("rst_trap_cnt", illegal_cnt, 0);
        chk("rst_trap_in_ready", in_ready, 1);

        $display("txn reset from mem_wait");
        accept(32'h00001067);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("mw_in_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mw_in_ready", in_ready, 1);
        chk("rst_mw_out_valid", out_valid, 0);
        chk("rst_mw_cmd", cmd, 0);
        chk("rst_mw_sx_cntl", sx_cntl, 3'b100);
        chk("rst_mw_mux_sel", mux_sel, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
